// File: rtl/mips_lsu_pkg.sv
// ============================================================================
// Module  : mips_lsu_pkg
// Brief   : Shared size encodings, FSM states and alignment check for mips_lsu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Size 2'b11 is treated as a word access, so it uses the word rule too.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_load_extend.sv
// ============================================================================
// Module  : mips_load_extend
// Brief   : Combinational sign/zero extender for right-justified load data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_load_extend
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'b0, i_data[7:0]}
                                         : {{24{i_data[7]}}, i_data[7:0]};
            SZ_HALF: o_data = i_unsigned ? {16'b0, i_data[15:0]}
                                         : {{16{i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_lsu.sv
// ============================================================================
// Module  : mips_lsu
// Brief   : MIPS load/store unit: drives the data-memory port, extends loads.
//           Optional alignment checking is enabled by MIPS_LSU_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte_en,
    output logic              mem_half_en,
    output logic              mem_word_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_misaligned;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_byte_en;
    logic              r_mem_half_en;
    logic              r_mem_word_en;

    logic              w_misaligned;
    logic [DATA_W-1:0] w_wdata_masked;
    logic [DATA_W-1:0] w_load_ext;

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_wdata_masked = req_wdata;
        case (req_size)
            SZ_BYTE: w_wdata_masked = {{(DATA_W-8){1'b0}},  req_wdata[7:0]};
            SZ_HALF: w_wdata_masked = {{(DATA_W-16){1'b0}}, req_wdata[15:0]};
            default: w_wdata_masked = req_wdata;
        endcase
    end

    mips_load_extend u_load_extend (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_data     (mem_rdata),
        .o_data     (w_load_ext)
    );

    // Memory-port and response registers default to 0 every cycle, so strobes
    // and the response are single-cycle pulses by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_req_ready      <= 1'b1;
            r_store          <= 1'b0;
            r_size           <= SZ_BYTE;
            r_unsigned       <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_misaligned <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_byte_en    <= 1'b0;
            r_mem_half_en    <= 1'b0;
            r_mem_word_en    <= 1'b0;
        end else begin
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_misaligned <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_byte_en    <= 1'b0;
            r_mem_half_en    <= 1'b0;
            r_mem_word_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_req_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_state          <= RESP;
                            r_rsp_valid      <= 1'b1;
                            r_rsp_misaligned <= 1'b1;
                        end else begin
                            r_state       <= ACCESS;
                            r_mem_addr    <= req_addr;
                            r_mem_wdata   <= req_store ? w_wdata_masked : '0;
                            r_mem_read    <= ~req_store;
                            r_mem_write   <= req_store;
                            r_mem_byte_en <= (req_size == SZ_BYTE);
                            r_mem_half_en <= (req_size == SZ_HALF);
                            r_mem_word_en <= req_size[1];
                        end
                    end
                end
                ACCESS: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_store ? '0 : w_load_ext;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_misaligned = r_rsp_misaligned;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_byte_en    = r_mem_byte_en;
    assign mem_half_en    = r_mem_half_en;
    assign mem_word_en    = r_mem_word_en;

endmodule

`default_nettype wire

// File: tb/tb_mips_lsu.sv
// ============================================================================
// Module  : tb_mips_lsu
// Brief   : Self-checking bench for mips_lsu with an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte_en;
    logic        mem_half_en;
    logic        mem_word_en;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_lsu dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_en    (mem_byte_en),
        .mem_half_en    (mem_half_en),
        .mem_word_en    (mem_word_en),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    // Load result from the size/sign rules, using modular arithmetic.
    function automatic logic [31:0] ref_load(input int sz, input bit uns, input logic [31:0] raw);
        longint m;
        longint v;
        if (nbytes(sz) == 4) return raw;
        m = longint'(1) << (8 * nbytes(sz));
        v = longint'(raw) % m;
        if (!uns && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input int sz, input logic [31:0] wd);
        longint m;
        longint v;
        if (nbytes(sz) == 4) return wd;
        m = longint'(1) << (8 * nbytes(sz));
        v = longint'(wd) % m;
        return v[31:0];
    endfunction

    function automatic bit ref_fault(input int sz, input logic [31:0] addr);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        return (longint'(addr) % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int budget;
        budget = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // One request from issue to return-to-idle, checked cycle by cycle.
    task automatic run_op(input string tag, input bit st, input int sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd);
        bit fault;
        fault = ref_fault(sz, addr);
        wait_ready();
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz[1:0];
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        mem_rdata    = rd;
        @(negedge clk);
        req_valid = 1'b0;
        if (fault) begin
            chk({tag, ".f_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, ".f_mis"},   {31'b0, rsp_misaligned}, 32'd1);
            chk({tag, ".f_rdata"}, rsp_rdata, 32'd0);
            chk({tag, ".f_strobe"}, {30'b0, mem_read, mem_write}, 32'd0);
        end else begin
            chk({tag, ".rd"},   {31'b0, mem_read},  {31'b0, !st});
            chk({tag, ".wr"},   {31'b0, mem_write}, {31'b0, st});
            chk({tag, ".en"},   {29'b0, mem_byte_en, mem_half_en, mem_word_en},
                                {29'b0, sz == 0, sz == 1, sz >= 2});
            chk({tag, ".addr"}, mem_addr, addr);
            if (st) chk({tag, ".wdata"}, mem_wdata, ref_store(sz, wd));
            chk({tag, ".early"}, {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
            chk({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, ".mis"},   {31'b0, rsp_misaligned}, 32'd0);
            chk({tag, ".rdata"}, rsp_rdata, st ? 32'd0 : ref_load(sz, uns, rd));
            chk({tag, ".strobe_off"}, {30'b0, mem_read, mem_write}, 32'd0);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, ".idle"},  {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int rsp_cycles[$];
        int n_pulse;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        chk("rst.rsp",   {30'b0, rsp_valid, rsp_misaligned}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.mem",   {27'b0, mem_read, mem_write, mem_byte_en, mem_half_en, mem_word_en}, 32'd0);
        chk("rst.maddr", mem_addr | mem_wdata, 32'd0);
        reset = 1'b0;

        run_op("lb",  1'b0, 0, 1'b0, 32'h4, 32'h0, 32'h0000_0080);
        run_op("lbu", 1'b0, 0, 1'b1, 32'h4, 32'h0, 32'h0000_0080);
        run_op("sh",  1'b1, 1, 1'b0, 32'h6, 32'hABCD_EF12, 32'h0);
        run_op("sb",  1'b1, 0, 1'b0, 32'h6, 32'h0000_0034, 32'h0);
        run_op("lhu", 1'b0, 1, 1'b1, 32'h6, 32'h0, 32'h0000_EF34);
        run_op("lh",  1'b0, 1, 1'b0, 32'h6, 32'h0, 32'h0000_EF34);
        run_op("lw2", 1'b0, 2, 1'b0, 32'h2, 32'h0, 32'h1234_5678);
        run_op("sz3", 1'b0, 3, 1'b0, 32'h8, 32'h0, 32'h8765_4321);

        // Reset during the ACCESS cycle of a store.
        wait_ready();
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr  = 32'h0; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.wr_on", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid.wr_off", {31'b0, mem_write}, 32'd0);
        chk("rstmid.no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rstmid.no_rsp2", {31'b0, rsp_valid}, 32'd0);
        chk("rstmid.ready",   {31'b0, req_ready}, 32'd1);

        // Back-to-back word loads with req_valid held high.
        wait_ready();
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr  = 32'h10; mem_rdata = 32'hCAFE_0001;
        n_pulse = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rsp_cycles.push_back(c);
                n_pulse++;
            end
        end
        req_valid = 1'b0;
        chk("b2b.count", n_pulse, 32'd4);
        chk("b2b.first", (rsp_cycles.size() > 0) ? rsp_cycles[0] : -1, 32'd2);
        for (int k = 1; k < rsp_cycles.size(); k++)
            chk("b2b.gap", rsp_cycles[k] - rsp_cycles[k-1], 32'd3);

        // Randomized requests against the reference model.
        for (int t = 0; t < 40; t++) begin
            run_op("rnd", ($urandom & 1) == 1, $urandom_range(0, 3), ($urandom & 1) == 1,
                   $urandom & 32'h3F, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit for the MIPS datapath. It accepts one load or store per request from the pipeline's MEM stage and drives the data-memory port: address, write data, read/write strobes and byte/halfword/word enables. For loads it captures the returned read data and sign- or zero-extends it. It returns a one-cycle response carrying the result, or a misalignment flag.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; fixed at 32 for MIPS, other values are unsupported.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word; 11 is illegal and treated as word.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for word loads and stores.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and faults.
- `rsp_misaligned` out 1: address fault; valid with `rsp_valid`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_byte_en` out 1: byte access enable.
- `mem_half_en` out 1: halfword access enable.
- `mem_word_en` out 1: word access enable.
- `mem_rdata` in DATA_W: memory read data; combinational and right-justified for byte/halfword.

## Operation
FSM states are IDLE, ACCESS and RESP.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch op, size, unsigned flag, address and data.
  - Go to ACCESS, or to RESP with fault set if misaligned.
- **ACCESS**
  - Exactly one size enable is high.
  - Exactly one of `mem_read` or `mem_write` is high.
  - `mem_addr` = latched address.
  - For loads, `mem_rdata` is sampled at the end of this cycle.
  - Always go to RESP.
- **RESP**
  - `rsp_valid`=1 for one cycle, then return to IDLE.

Store data masking:
- Byte: `mem_wdata` = {24'b0, wdata[7:0]}.
- Halfword: {16'b0, wdata[15:0]}.
- Word: unchanged.

Load extension:
- Byte: sign-extend bit 7, or zero-extend when `req_unsigned`.
- Halfword: sign-extend bit 15, or zero-extend when `req_unsigned`.
- Word: passed through unchanged.

Misalignment:
- Halfword with addr[0]≠0, or word with addr[1:0]≠0.
- No memory strobe is issued.
- `rsp_misaligned`=1, `rsp_rdata`=0.

All `mem_*` and `rsp_*` outputs are registered. Outside ACCESS, all strobes and enables are 0, and `mem_addr`/`mem_wdata` are 0.

## Timing
- **Reset:** all outputs are 0 except `req_ready`=1; the state is IDLE.
- **Normal request:** accepted at edge N; strobes are high during cycle N+1; `rsp_valid` is high during cycle N+2.
- **Misaligned request:** accepted at edge N; `rsp_valid` is high during cycle N+1; no strobe in any cycle.
- **Throughput:** one request per 3 cycles, or per 2 for faults. A request held valid during ACCESS or RESP is not accepted and must be held by the requester.
- **No backpressure on responses:** `rsp_valid` is a single-cycle pulse that the consumer must take.
- **Reset mid-operation:**
  - `reset` sampled high during ACCESS: strobes drop at the next edge and no response is produced.
  - The write strobe is never asserted for more than one cycle per store.
- **Write strobe:** `mem_write` is asserted for exactly one cycle, with address, data and enables stable for that whole cycle.

## Configuration
Macro: `MIPS_LSU_ALIGN_CHECK_EN`.
- **Defined:** misalignment detection as above.
- **Undefined:**
  - No check; every request goes through ACCESS.
  - `rsp_misaligned` is tied 0.
  - Misaligned addresses are passed to memory unchanged.

## Structure
Shared package `mips_lsu_pkg` holds:
- the size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
- the state enum (IDLE, ACCESS, RESP);
- the alignment-check function.

One sub-module: `mips_load_extend`, a combinational extender with inputs size, unsigned flag and raw data, and output extended data. The FSM, latches and write masking stay in `mips_lsu`.

## Test plan
1. LB at 0x4, memory returns 0x00000080:
   - `mem_read`=1 and `mem_byte_en`=1 for one cycle;
   - `rsp_rdata`=0xFFFFFF80 two cycles after accept.
   - LBU of the same access returns 0x00000080.
2. SH at 0x6 with wdata 0xABCDEF12:
   - `mem_write`=1 and `mem_half_en`=1 for one cycle;
   - `mem_addr`=0x6, `mem_wdata`=0x0000EF12;
   - `rsp_valid` with `rsp_rdata`=0.
3. SB at 0x6 with 0x00000034, then LHU at 0x6 with memory returning 0x0000EF34 → `rsp_rdata`=0x0000EF34. LH of the same access returns 0xFFFFEF34.
4. LW at 0x2 with the macro defined:
   - no strobe asserted;
   - `rsp_valid` and `rsp_misaligned`=1 one cycle after accept;
   - `rsp_rdata`=0.
   - Without the macro: a normal read at 0x2.
5. SW at 0x0 with reset asserted during ACCESS:
   - `mem_write` drops at the next edge;
   - no `rsp_valid`;
   - `req_ready`=1 after reset.
6. Two back-to-back LW requests with `req_valid` held high: the second is accepted only when back in IDLE, with `rsp_valid` pulses exactly 3 cycles apart.
